riscv_hazard_scoreboard: RTL and testbench



---
 rtl/riscv_hazard_scoreboard_if.sv | 28 ++
 rtl/riscv_hazard_scoreboard.sv | 83 ++++++++
 tb/tb_riscv_hazard_scoreboard.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/riscv_hazard_scoreboard_if.sv
// rtl/riscv_hazard_scoreboard_if.sv - ID-to-scoreboard issue handshake bundle
// The ID stage drives the decoded operand/destination fields; the scoreboard answers with stall/issue.
interface riscv_hazard_scoreboard_if #(
   parameter int LAT_W = 4
);
   logic             id_valid;
   logic [4:0]       id_rs1_addr;
   logic             id_rs1_used;
   logic [4:0]       id_rs2_addr;
   logic             id_rs2_used;
   logic [4:0]       id_rd_addr;
   logic             id_rd_we;
   logic [LAT_W-1:0] id_lat;
   logic             stall;
   logic             issue;

   modport master (
      output id_valid, id_rs1_addr, id_rs1_used, id_rs2_addr, id_rs2_used,
             id_rd_addr, id_rd_we, id_lat,
      input  stall, issue
   );

   modport slave (
      input  id_valid, id_rs1_addr, id_rs1_used, id_rs2_addr, id_rs2_used,
             id_rd_addr, id_rd_we, id_lat,
      output stall, issue
   );
endinterface

// File: rtl/riscv_hazard_scoreboard.sv
// rtl/riscv_hazard_scoreboard.sv - register-dependency scoreboard and issue control between ID and EX1
// Optional hazard-stall performance counter: define RISCV_SB_PERF_CNT_EN.
module riscv_hazard_scoreboard #(
   parameter int NUM_REGS = 32,
   parameter int LAT_W    = 4,
   parameter int MAX_LAT  = 10
) (
   input  logic                         clk,
   input  logic                         rst_n,
   riscv_hazard_scoreboard_if.slave     id,
   input  logic                         ext_stall,
   input  logic                         flush,
   output logic [NUM_REGS-1:0]          busy_vec,
   output logic [31:0]                  perf_stall_cnt
);
   localparam logic [LAT_W-1:0] MAX_LAT_V = LAT_W'(MAX_LAT);

   logic [LAT_W-1:0] cnt     [NUM_REGS];
   logic [LAT_W-1:0] cnt_nxt [NUM_REGS];
   logic [LAT_W-1:0] lat_c;
   logic [LAT_W-1:0] lat_load;
   logic             raw;
   logic             waw;
   logic             hazard;
   logic             rd_track;

   // cnt holds the number of cycles a consumer must still wait, so a latency-L
   // producer loads L-1 and its consumer issues exactly L cycles after it.
   always_comb begin
      lat_c    = (id.id_lat > MAX_LAT_V) ? MAX_LAT_V : id.id_lat;
      lat_load = (lat_c == '0) ? '0 : lat_c - LAT_W'(1);
      raw      = (id.id_rs1_used && (id.id_rs1_addr != '0) && busy_vec[id.id_rs1_addr]) ||
                 (id.id_rs2_used && (id.id_rs2_addr != '0) && busy_vec[id.id_rs2_addr]);
      rd_track = id.id_rd_we && (id.id_rd_addr != '0);
      waw      = rd_track && busy_vec[id.id_rd_addr] && (cnt[id.id_rd_addr] >= lat_c);
      hazard   = raw || waw;
   end

   assign id.stall = rst_n && id.id_valid && (hazard || ext_stall);
   assign id.issue = rst_n && id.id_valid && !id.stall && !flush;

   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) begin
         if (flush) begin
            cnt_nxt[r] = '0;
         end else if (ext_stall || (cnt[r] == '0)) begin
            cnt_nxt[r] = cnt[r];
         end else begin
            cnt_nxt[r] = cnt[r] - LAT_W'(1);
         end
      end
      if (id.issue && rd_track) begin
         cnt_nxt[id.id_rd_addr] = lat_load;
      end
      cnt_nxt[0] = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            cnt[r] <= '0;
         end
         busy_vec <= '0;
      end else begin
         for (int r = 0; r < NUM_REGS; r++) begin
            cnt[r]      <= cnt_nxt[r];
            busy_vec[r] <= (cnt_nxt[r] != '0);
         end
      end
   end

`ifdef RISCV_SB_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_stall_cnt <= '0;
      end else if (id.id_valid && hazard && !ext_stall && !flush && (perf_stall_cnt != '1)) begin
         perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
   end
`else
   assign perf_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_riscv_hazard_scoreboard.sv
// tb/tb_riscv_hazard_scoreboard.sv - directed and random checks of riscv_hazard_scoreboard
module tb_riscv_hazard_scoreboard;
   localparam int NR = 32;
   localparam int LW = 4;
   localparam int ML = 10;
`ifdef RISCV_SB_PERF_CNT_EN
   localparam bit PERF_EN = 1'b1;
`else
   localparam bit PERF_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          ext_stall = 1'b0;
   logic          flush = 1'b0;
   logic [NR-1:0] busy_vec;
   logic [31:0]   perf_stall_cnt;

   riscv_hazard_scoreboard_if #(.LAT_W(LW)) sbif ();

   riscv_hazard_scoreboard #(.NUM_REGS(NR), .LAT_W(LW), .MAX_LAT(ML)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .id             (sbif),
      .ext_stall      (ext_stall),
      .flush          (flush),
      .busy_vec       (busy_vec),
      .perf_stall_cnt (perf_stall_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: time advances on every non-frozen cycle; avail[r] is the
   // model time at which register r becomes forwardable.
   longint        now_t;
   longint        avail [NR];
   longint        perf_m;
   logic [NR-1:0] bv_s;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      now_t  = 0;
      perf_m = 0;
      for (int r = 0; r < NR; r++) avail[r] = 0;
   endtask

   function automatic bit m_busy(input int r);
      return (r != 0) && (avail[r] > now_t);
   endfunction

   task automatic drive(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                        input int rd, input bit we, input int lat, input bit es, input bit fl);
      sbif.id_valid    = v;
      sbif.id_rs1_addr = 5'(rs1);
      sbif.id_rs1_used = u1;
      sbif.id_rs2_addr = 5'(rs2);
      sbif.id_rs2_used = u2;
      sbif.id_rd_addr  = 5'(rd);
      sbif.id_rd_we    = we;
      sbif.id_lat      = LW'(lat);
      ext_stall        = es;
      flush            = fl;
   endtask

   // One pipeline cycle: sample at negedge, compare with the model, advance the model.
   task automatic cyc(input string tag, input int es, input int ei);
      int            latc, rs1, rs2, rd;
      bit            raw, waw, st, is, v, we;
      logic [NR-1:0] bm;
      @(negedge clk);
      v    = sbif.id_valid;
      we   = sbif.id_rd_we;
      rs1  = int'(sbif.id_rs1_addr);
      rs2  = int'(sbif.id_rs2_addr);
      rd   = int'(sbif.id_rd_addr);
      latc = (int'(sbif.id_lat) > ML) ? ML : int'(sbif.id_lat);
      for (int r = 0; r < NR; r++) bm[r] = m_busy(r);
      raw = (sbif.id_rs1_used && m_busy(rs1)) || (sbif.id_rs2_used && m_busy(rs2));
      waw = we && (rd != 0) && m_busy(rd) && ((avail[rd] - now_t) >= latc);
      st  = v && (raw || waw || ext_stall);
      is  = v && !st && !flush;
      check({tag, "_stall"}, 64'(sbif.stall), 64'(st));
      check({tag, "_issue"}, 64'(sbif.issue), 64'(is));
      check({tag, "_busy"}, 64'(busy_vec), 64'(bm));
      check({tag, "_perf"}, 64'(perf_stall_cnt), PERF_EN ? 64'(perf_m) : 64'd0);
      if (es >= 0) check({tag, "_dstall"}, 64'(sbif.stall), 64'(es));
      if (ei >= 0) check({tag, "_dissue"}, 64'(sbif.issue), 64'(ei));
      bv_s = busy_vec;
      if (v && (raw || waw) && !ext_stall && !flush && perf_m != 64'hFFFF_FFFF) perf_m++;
      if (flush) begin
         for (int r = 0; r < NR; r++) avail[r] = now_t;
         now_t++;
      end else if (!ext_stall) begin
         if (is && we && rd != 0) avail[rd] = now_t + latc;
         now_t++;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      model_reset();
      drive(1, 5, 1, 6, 1, 7, 1, 3, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_stall", 64'(sbif.stall), 64'd0);
      check("rst_issue", 64'(sbif.issue), 64'd0);
      check("rst_busy", 64'(busy_vec), 64'd0);
      check("rst_perf", 64'(perf_stall_cnt), 64'd0);
      rst_n = 1'b1;

      // RAW: producer x5 lat 3, consumer stalls two cycles then issues
      drive(1, 0, 0, 0, 0, 5, 1, 3, 0, 0);  cyc("s1p", 0, 1);
      drive(1, 5, 1, 0, 0, 6, 1, 1, 0, 0);  cyc("s1c0", 1, 0);
      check("s1_busy5_set", 64'(bv_s[5]), 64'd1);
      cyc("s1c1", 1, 0);
      cyc("s1c2", 0, 1);
      check("s1_busy5_clr", 64'(bv_s[5]), 64'd0);
      check("s1_perf_total", 64'(perf_stall_cnt), PERF_EN ? 64'd2 : 64'd0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  cyc("idle", -1, -1);

      // RAW across an external freeze: issue lands 6 cycles after producer
      drive(1, 0, 0, 0, 0, 7, 1, 4, 0, 0);  cyc("s2p", 0, 1);
      drive(1, 1, 0, 7, 1, 8, 1, 0, 0, 0);  cyc("s2c0", 1, 0);
      ext_stall = 1'b1;                     cyc("s2e0", 1, 0);
      cyc("s2e1", 1, 0);
      check("s2_busy7_frozen", 64'(bv_s[7]), 64'd1);
      ext_stall = 1'b0;                     cyc("s2c1", 1, 0);
      cyc("s2c2", 1, 0);
      cyc("s2c3", 0, 1);

      // WAW: older lat-6 write to x9 must not complete after a younger lat-2 write
      drive(1, 0, 0, 0, 0, 9, 1, 6, 0, 0);  cyc("s3p", 0, 1);
      drive(1, 0, 0, 0, 0, 9, 1, 2, 0, 0);
      for (int k = 0; k < 4; k++) cyc("s3w", 1, 0);
      cyc("s3wi", 0, 1);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  cyc("idle", -1, -1);
      cyc("idle", -1, -1);

      // x0 is never tracked
      drive(1, 0, 0, 0, 0, 0, 1, 5, 0, 0);  cyc("s4p", 0, 1);
      drive(1, 0, 1, 0, 1, 0, 1, 5, 0, 0);  cyc("s4c", 0, 1);
      check("s4_busy_none", 64'(busy_vec), 64'd0);

      // flush squashes the stalled dependent, clears all entries
      drive(1, 0, 0, 0, 0, 3, 1, 5, 0, 0);  cyc("s5p3", 0, 1);
      drive(1, 0, 0, 0, 0, 4, 1, 8, 0, 0);  cyc("s5p4", 0, 1);
      drive(1, 4, 1, 3, 1, 11, 1, 0, 0, 1); cyc("s5f", 1, 0);
      flush = 1'b0;                         cyc("s5d", 0, 1);
      check("s5_busy_clear", 64'(bv_s), 64'd0);

      // clamp: lat 15 behaves as 10
      drive(1, 0, 0, 0, 0, 12, 1, 15, 0, 0); cyc("s6p", 0, 1);
      drive(1, 12, 1, 0, 0, 13, 0, 0, 0, 0);
      for (int k = 0; k < 9; k++) cyc("s6w", 1, 0);
      cyc("s6i", 0, 1);

      // reset mid-countdown clears state at once
      drive(1, 0, 0, 0, 0, 10, 1, 8, 0, 0); cyc("s7p", 0, 1);
      drive(1, 10, 1, 0, 0, 14, 1, 2, 0, 0);
      rst_n = 1'b0;
      #2;
      check("s7_rst_busy", 64'(busy_vec), 64'd0);
      check("s7_rst_stall", 64'(sbif.stall), 64'd0);
      check("s7_rst_issue", 64'(sbif.issue), 64'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc("s7c", 0, 1);

      for (int i = 0; i < 600; i++) begin
         drive($urandom_range(0, 3) != 0,
               int'($urandom_range(0, 7)), $urandom_range(0, 1) != 0,
               int'($urandom_range(0, 7)), $urandom_range(0, 1) != 0,
               int'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
               int'($urandom_range(0, 15)),
               $urandom_range(0, 7) == 0, $urandom_range(0, 24) == 0);
         cyc("rnd", -1, -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
